vx_fp_bf16_sqrt_ctrl: RTL and testbench
=======================================

VX_FP_BF16_SQRT_CTRL -- requirements
Module: VX_fp_bf16_sqrt_ctrl

Interface
REQ-001 SHALL have parameter TAGW, default 1, meaning request tag width.
REQ-002 SHALL have parameter LANES, default 1, meaning vector lanes served by one shared single-lane BF16 sqrt core.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 valid_in / ready_in  in / out  1 / 1  upstream request handshake.
REQ-006 tag_in  in  TAGW  request tag; frm  in  INST_FRM_BITS  rounding mode.
REQ-007 dataa  in  LANES x 32  operands; only bits [31:16] (BF16) are used.
REQ-008 lane_mask  in  LANES  1 = lane active.
REQ-009 result  out  LANES x 16  BF16 results; fflags  out  LANES x fflags_t; has_fflags  out  1.
REQ-010 tag_out  out  TAGW; valid_out  out  1; ready_out  in  1  downstream handshake.
REQ-011 core_valid  out  1; core_ready  in  1; core_data  out  16; core_frm  out  INST_FRM_BITS  core issue port.
REQ-012 core_rsp_valid  in  1; core_rsp_data  in  16; core_rsp_fflags  in  fflags_t  core response port, no back-pressure, in-order.

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, DRAIN, DONE.
REQ-014 ready_in SHALL be 1 only in IDLE; acceptance = valid_in && ready_in.
REQ-015 On acceptance SHALL capture dataa[i][31:16], lane_mask, tag_in, frm; clear result/fflags buffers to 0; go to ISSUE, or to DONE if lane_mask == 0.
REQ-016 ISSUE: issue pointer walks lanes 0..LANES-1 ascending; active lane -> core_valid=1, core_data = captured lane operand, core_frm = captured frm; pointer advances on core_valid && core_ready; inactive lane skipped at one lane per cycle with core_valid=0.
REQ-017 After the last lane is passed, SHALL go to DONE if outstanding count == 0 (including a response in that same cycle), else DRAIN.
REQ-018 Outstanding count SHALL increment on issue, decrement on core_rsp_valid, both in one cycle = unchanged; width clog2(LANES+1).
REQ-019 Each core_rsp_valid SHALL write data/fflags into the lowest active lane not yet written (return pointer); responses SHALL be accepted in ISSUE and DRAIN.
REQ-020 DRAIN -> DONE on the cycle outstanding becomes 0.
REQ-021 DONE: valid_out=1, result/fflags/tag_out stable; on ready_out -> IDLE.
REQ-022 Masked-off lanes SHALL return result 0, fflags 0.
REQ-023 has_fflags SHALL be constant 1.
REQ-024 core_rsp_valid in IDLE or DONE SHALL be ignored (no state change).
REQ-025 Latency, all lanes active, core always ready, fixed core latency L>=1, accept at cycle T: lane k issued T+1+k; valid_out first high at T+LANES+L+1.
REQ-026 No new request SHALL be accepted before the previous result handshake completes.

Reset
REQ-027 On reset: state IDLE, pointers and outstanding 0, result/fflags/tag_out 0, valid_out 0, core_valid 0, ready_in 1 the cycle after.
REQ-028 Reset mid-operation SHALL abandon the request; later core responses handled per REQ-024.

Structure
REQ-029 fflags_t and INST_FRM_BITS SHALL come from the shared FPU definitions; state encoding stays local.
REQ-030 No internal sub-module; parent instantiates single-lane core VX_fp_bf16_sqrt_lane beside this controller.

Verification
REQ-031 LANES=4, mask 4'b1111, operands 0x4080, 0x3F80, 0x4110, 0x0000 (upper halves), core model L=3 -> results 0x4000, 0x3F80, 0x4040, 0x0000; valid_out at T+8.
REQ-032 LANES=4, mask 4'b0101 -> exactly 2 core issues (lanes 0, 2); result[1]=result[3]=0, fflags 0.
REQ-033 mask 0 -> zero core issues, valid_out at T+1, all results 0.
REQ-034 core_ready toggled randomly, ready_out held 0 for 5 cycles in DONE -> outputs stable, ready_in 0 throughout, correct lane ordering.
REQ-035 reset asserted in DRAIN with 2 outstanding, then stray core_rsp_valid -> IDLE, outputs 0, stray responses ignored; next request correct.
REQ-036 core model NaN input 0xFFC1 returns fflags NV -> NV appears only in that lane's fflags.

Source files
------------

// File: rtl/vx_fp_bf16_sqrt_ctrl_pkg.sv
// Shared FPU definitions used by the BF16 sqrt lane controller.
//   INST_FRM_BITS : width of the rounding-mode field
//   fflags_t      : IEEE exception flags {nv, dz, of, uf, nx}, nv in the MSB
package vx_fp_bf16_sqrt_ctrl_pkg;

   localparam int unsigned INST_FRM_BITS = 3;

   typedef struct packed {
      logic nv;
      logic dz;
      logic of;
      logic uf;
      logic nx;
   } fflags_t;

endpackage

// File: rtl/vx_fp_bf16_sqrt_ctrl.sv
// Serialises a LANES-wide BF16 sqrt request onto one shared single-lane core and
// gathers the in-order responses back into a vector result.
// Ports:
//   clk, reset                    : clock, synchronous active-high reset
//   valid_in/ready_in, tag_in,    : upstream request (operands in dataa[i][31:16])
//   frm, dataa, lane_mask
//   result, fflags, has_fflags,   : downstream response, held stable until ready_out
//   tag_out, valid_out, ready_out
//   core_valid/core_ready,        : issue port to the single-lane core
//   core_data, core_frm
//   core_rsp_valid, core_rsp_data,: in-order core responses, no back-pressure
//   core_rsp_fflags
module vx_fp_bf16_sqrt_ctrl
   import vx_fp_bf16_sqrt_ctrl_pkg::*;
#(
   parameter int unsigned TAGW  = 1,
   parameter int unsigned LANES = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           valid_in,
   output logic                           ready_in,
   input  logic [TAGW-1:0]                tag_in,
   input  logic [INST_FRM_BITS-1:0]       frm,
   input  logic [LANES-1:0][31:0]         dataa,
   input  logic [LANES-1:0]               lane_mask,
   output logic [LANES-1:0][15:0]         result,
   output fflags_t [LANES-1:0]            fflags,
   output logic                           has_fflags,
   output logic [TAGW-1:0]                tag_out,
   output logic                           valid_out,
   input  logic                           ready_out,
   output logic                           core_valid,
   input  logic                           core_ready,
   output logic [15:0]                    core_data,
   output logic [INST_FRM_BITS-1:0]       core_frm,
   input  logic                           core_rsp_valid,
   input  logic [15:0]                    core_rsp_data,
   input  fflags_t                        core_rsp_fflags
);

   localparam int unsigned PtrW = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned CntW = $clog2(LANES + 1);

   typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

   state_e                     state_q, state_d;
   logic [PtrW-1:0]            ptr_q, ptr_d;
   logic [CntW-1:0]            cnt_q, cnt_d;
   logic [LANES-1:0]           mask_q, mask_d;
   logic [LANES-1:0]           wr_q, wr_d;      // lanes whose response has landed
   logic [LANES-1:0][15:0]     ops_q, ops_d;
   logic [LANES-1:0][15:0]     res_q, res_d;
   fflags_t [LANES-1:0]        flg_q, flg_d;
   logic [TAGW-1:0]            tag_q, tag_d;
   logic [INST_FRM_BITS-1:0]   frm_q, frm_d;

   logic                       accept;
   logic                       cur_active;
   logic [15:0]                cur_data;
   logic                       issue_fire;
   logic                       ptr_adv;
   logic                       ptr_last;
   logic                       rsp_fire;
   logic [CntW-1:0]            cnt_nxt;
   logic [LANES-1:0]           ret_sel;
   logic                       ret_found;

   // Low halves of the operands carry no BF16 information.
   logic [LANES-1:0][15:0]     dataa_lo;
   logic                       unused_dataa_lo;

   always_comb begin
      for (int i = 0; i < LANES; i++) begin
         dataa_lo[i] = dataa[i][15:0];
      end
   end
   assign unused_dataa_lo = ^dataa_lo;

   // Select the lane under the issue pointer by compare rather than index so
   // that the LANES == 1 case needs no zero-width pointer.
   always_comb begin
      cur_active = 1'b0;
      cur_data   = '0;
      for (int i = 0; i < LANES; i++) begin
         if (ptr_q == PtrW'(i)) begin
            cur_active = mask_q[i];
            cur_data   = ops_q[i];
         end
      end
   end

   // Return pointer: lowest active lane still waiting for its response.
   always_comb begin
      ret_sel   = '0;
      ret_found = 1'b0;
      for (int i = 0; i < LANES; i++) begin
         if (!ret_found && mask_q[i] && !wr_q[i]) begin
            ret_sel[i] = 1'b1;
            ret_found  = 1'b1;
         end
      end
   end

   assign accept     = valid_in && (state_q == StIdle);
   assign issue_fire = (state_q == StIssue) && cur_active && core_ready;
   assign ptr_adv    = (state_q == StIssue) && (!cur_active || core_ready);
   assign ptr_last   = (ptr_q == PtrW'(LANES - 1));
   assign rsp_fire   = core_rsp_valid && ((state_q == StIssue) || (state_q == StDrain));
   assign cnt_nxt    = cnt_q + CntW'(issue_fire) - CntW'(rsp_fire);

   // State register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = (lane_mask == '0) ? StDone : StIssue;
            end
         end
         StIssue: begin
            // cnt_nxt already folds in a response landing this same cycle.
            if (ptr_adv && ptr_last) begin
               state_d = (cnt_nxt == '0) ? StDone : StDrain;
            end
         end
         StDrain: begin
            if (cnt_nxt == '0) begin
               state_d = StDone;
            end
         end
         StDone: begin
            if (ready_out) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      ready_in   = (state_q == StIdle);
      valid_out  = (state_q == StDone);
      core_valid = (state_q == StIssue) && cur_active;
      core_data  = core_valid ? cur_data : 16'h0000;
      core_frm   = frm_q;
      result     = res_q;
      fflags     = flg_q;
      tag_out    = tag_q;
      has_fflags = 1'b1;
   end

   // Datapath next-state
   always_comb begin
      ptr_d  = ptr_q;
      cnt_d  = cnt_q;
      mask_d = mask_q;
      wr_d   = wr_q;
      ops_d  = ops_q;
      res_d  = res_q;
      flg_d  = flg_q;
      tag_d  = tag_q;
      frm_d  = frm_q;
      if (accept) begin
         ptr_d  = '0;
         cnt_d  = '0;
         mask_d = lane_mask;
         wr_d   = '0;
         res_d  = '0;
         flg_d  = '0;
         tag_d  = tag_in;
         frm_d  = frm;
         for (int i = 0; i < LANES; i++) begin
            ops_d[i] = dataa[i][31:16];
         end
      end else begin
         // The pointer parks on the last lane once it has been passed.
         if (ptr_adv && !ptr_last) begin
            ptr_d = ptr_q + PtrW'(1);
         end
         cnt_d = cnt_nxt;
         if (rsp_fire) begin
            for (int i = 0; i < LANES; i++) begin
               if (ret_sel[i]) begin
                  res_d[i] = core_rsp_data;
                  flg_d[i] = core_rsp_fflags;
                  wr_d[i]  = 1'b1;
               end
            end
         end
      end
   end

   // Datapath registers
   always_ff @(posedge clk) begin
      if (reset) begin
         ptr_q  <= '0;
         cnt_q  <= '0;
         mask_q <= '0;
         wr_q   <= '0;
         ops_q  <= '0;
         res_q  <= '0;
         flg_q  <= '0;
         tag_q  <= '0;
         frm_q  <= '0;
      end else begin
         ptr_q  <= ptr_d;
         cnt_q  <= cnt_d;
         mask_q <= mask_d;
         wr_q   <= wr_d;
         ops_q  <= ops_d;
         res_q  <= res_d;
         flg_q  <= flg_d;
         tag_q  <= tag_d;
         frm_q  <= frm_d;
      end
   end

endmodule

// File: tb/tb_vx_fp_bf16_sqrt_ctrl.sv
// Directed bench for vx_fp_bf16_sqrt_ctrl with LANES=4 and a fixed-latency (3) core model.
module tb_vx_fp_bf16_sqrt_ctrl;
   import vx_fp_bf16_sqrt_ctrl_pkg::*;

   localparam int unsigned TAGW  = 4;
   localparam int unsigned LANES = 4;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     valid_in;
   logic                     ready_in;
   logic [TAGW-1:0]          tag_in;
   logic [INST_FRM_BITS-1:0] frm;
   logic [LANES-1:0][31:0]   dataa;
   logic [LANES-1:0]         lane_mask;
   logic [LANES-1:0][15:0]   result;
   fflags_t [LANES-1:0]      fflags;
   logic                     has_fflags;
   logic [TAGW-1:0]          tag_out;
   logic                     valid_out;
   logic                     ready_out;
   logic                     core_valid;
   logic                     core_ready;
   logic [15:0]              core_data;
   logic [INST_FRM_BITS-1:0] core_frm;
   logic                     core_rsp_valid;
   logic [15:0]              core_rsp_data;
   fflags_t                  core_rsp_fflags;

   int checks = 0;
   int errors = 0;

   vx_fp_bf16_sqrt_ctrl #(
      .TAGW  (TAGW),
      .LANES (LANES)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .valid_in        (valid_in),
      .ready_in        (ready_in),
      .tag_in          (tag_in),
      .frm             (frm),
      .dataa           (dataa),
      .lane_mask       (lane_mask),
      .result          (result),
      .fflags          (fflags),
      .has_fflags      (has_fflags),
      .tag_out         (tag_out),
      .valid_out       (valid_out),
      .ready_out       (ready_out),
      .core_valid      (core_valid),
      .core_ready      (core_ready),
      .core_data       (core_data),
      .core_frm        (core_frm),
      .core_rsp_valid  (core_rsp_valid),
      .core_rsp_data   (core_rsp_data),
      .core_rsp_fflags (core_rsp_fflags)
   );

   always #5 clk = ~clk;

   // Core model: table-driven BF16 sqrt, 3-cycle fixed latency.
   function automatic logic [15:0] core_sqrt(input logic [15:0] a);
      case (a)
         16'h4080: return 16'h4000;
         16'h3F80: return 16'h3F80;
         16'h4110: return 16'h4040;
         16'h0000: return 16'h0000;
         16'hFFC1: return 16'h7FC0;
         default:  return 16'hDEAD;
      endcase
   endfunction

   function automatic logic [4:0] core_flags(input logic [15:0] a);
      return (a == 16'hFFC1) ? 5'b10000 : 5'b00000;
   endfunction

   logic [2:0]       pv = '0;
   logic [2:0][15:0] pd = '0;
   always @(posedge clk) begin
      pv <= {pv[1:0], core_valid && core_ready};
      pd <= {pd[1:0], core_data};
   end
   assign core_rsp_valid  = pv[2];
   assign core_rsp_data   = core_sqrt(pd[2]);
   assign core_rsp_fflags = core_flags(pd[2]);

   // Issue log
   int          n_issue = 0;
   logic [15:0] issued_log [0:63];
   always @(posedge clk) begin
      if (core_valid && core_ready) begin
         issued_log[n_issue[5:0]] <= core_data;
         n_issue                  <= n_issue + 1;
      end
   end

   logic rand_ready = 1'b0;
   always @(negedge clk) begin
      core_ready <= rand_ready ? 1'($urandom) : 1'b1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one request at a negedge; returns after the acceptance edge (+1).
   task automatic send(input logic [3:0] m, input logic [63:0] ops, input logic [3:0] t,
                       input logic [2:0] f);
      @(negedge clk);
      chk("ready_in_before_send", 32'(ready_in), 32'd1);
      valid_in  = 1'b1;
      lane_mask = m;
      tag_in    = t;
      frm       = f;
      for (int i = 0; i < LANES; i++) begin
         dataa[i] = {ops[i*16 +: 16], 16'hABCD};
      end
      @(posedge clk);
      #1;
      // Scramble inputs so only captured values can reach the outputs.
      valid_in  = 1'b0;
      dataa     = '1;
      lane_mask = '1;
      tag_in    = ~t;
      frm       = ~f;
      chk("ready_in_after_accept", 32'(ready_in), 32'd0);
      chk("core_frm_captured", 32'(core_frm), 32'(f));
   endtask

   // Counts edges after acceptance until valid_out rises.
   task automatic wait_done(output int n);
      logic saw_rdy;
      n       = 0;
      saw_rdy = 1'b0;
      while (!valid_out && n < 200) begin
         if (ready_in) saw_rdy = 1'b1;
         @(posedge clk);
         #1;
         n++;
      end
      chk("valid_out_reached", 32'(valid_out), 32'd1);
      chk("ready_in_low_busy", 32'(saw_rdy), 32'd0);
   endtask

   task automatic chk_results(input logic [63:0] er, input logic [19:0] ef, input logic [3:0] et);
      for (int i = 0; i < LANES; i++) begin
         chk($sformatf("result%0d", i), 32'(result[i]), 32'(er[i*16 +: 16]));
      end
      chk("fflags", 32'(fflags), 32'(ef));
      chk("tag_out", 32'(tag_out), 32'(et));
   endtask

   task automatic handshake();
      @(negedge clk);
      ready_out = 1'b1;
      @(posedge clk);
      #1;
      ready_out = 1'b0;
      chk("idle_after_handshake", 32'(ready_in), 32'd1);
      chk("valid_out_dropped", 32'(valid_out), 32'd0);
   endtask

   initial begin
      int n;
      int base;
      reset     = 1'b1;
      valid_in  = 1'b0;
      tag_in    = '0;
      frm       = '0;
      dataa     = '0;
      lane_mask = '0;
      ready_out = 1'b0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_ready_in", 32'(ready_in), 32'd1);
      chk("rst_valid_out", 32'(valid_out), 32'd0);
      chk("rst_core_valid", 32'(core_valid), 32'd0);
      chk("rst_has_fflags", 32'(has_fflags), 32'd1);
      chk_results(64'h0, 20'h0, 4'h0);

      // All lanes active, latency T+8 (7 edges after the acceptance edge)
      base = n_issue;
      send(4'b1111, {16'h0000, 16'h4110, 16'h3F80, 16'h4080}, 4'hA, 3'd1);
      wait_done(n);
      chk("latency_full", 32'(n), 32'd7);
      chk_results({16'h0000, 16'h4040, 16'h3F80, 16'h4000}, 20'h0, 4'hA);
      chk("issues_full", 32'(n_issue - base), 32'd4);
      chk("order_full0", 32'(issued_log[6'(base)]), 32'h4080);
      chk("order_full3", 32'(issued_log[6'(base + 3)]), 32'h0000);
      handshake();

      // Sparse mask: lanes 0 and 2 only
      base = n_issue;
      send(4'b0101, {16'h5678, 16'h4110, 16'h1234, 16'h4080}, 4'h5, 3'd2);
      wait_done(n);
      chk_results({16'h0000, 16'h4040, 16'h0000, 16'h4000}, 20'h0, 4'h5);
      chk("issues_sparse", 32'(n_issue - base), 32'd2);
      chk("order_sparse0", 32'(issued_log[6'(base)]), 32'h4080);
      chk("order_sparse1", 32'(issued_log[6'(base + 1)]), 32'h4110);
      handshake();

      // Empty mask: straight to DONE
      base = n_issue;
      send(4'b0000, {16'h4080, 16'h4080, 16'h4080, 16'h4080}, 4'h3, 3'd0);
      chk("valid_out_mask0", 32'(valid_out), 32'd1);
      wait_done(n);
      chk("latency_mask0", 32'(n), 32'd0);
      chk_results(64'h0, 20'h0, 4'h3);
      chk("issues_mask0", 32'(n_issue - base), 32'd0);
      handshake();

      // Random core_ready, downstream stall in DONE
      rand_ready = 1'b1;
      base = n_issue;
      send(4'b1111, {16'h3F80, 16'h0000, 16'h4080, 16'h4110}, 4'h9, 3'd4);
      wait_done(n);
      rand_ready = 1'b0;
      chk_results({16'h3F80, 16'h0000, 16'h4000, 16'h4040}, 20'h0, 4'h9);
      chk("issues_rand", 32'(n_issue - base), 32'd4);
      chk("order_rand1", 32'(issued_log[6'(base + 1)]), 32'h4080);
      chk("order_rand2", 32'(issued_log[6'(base + 2)]), 32'h0000);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         chk("stall_valid_out", 32'(valid_out), 32'd1);
         chk("stall_ready_in", 32'(ready_in), 32'd0);
         chk("stall_result2", 32'(result[2]), 32'h0000);
         chk("stall_result3", 32'(result[3]), 32'h3F80);
      end
      handshake();

      // Reset in DRAIN with two responses outstanding
      base = n_issue;
      send(4'b1111, {16'h0000, 16'h4110, 16'h3F80, 16'h4080}, 4'h7, 3'd3);
      repeat (5) @(posedge clk);
      #1;
      chk("drain_core_valid", 32'(core_valid), 32'd0);
      chk("drain_busy", 32'(ready_in), 32'd0);
      chk("drain_issues", 32'(n_issue - base), 32'd4);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("mid_rst_ready_in", 32'(ready_in), 32'd1);
      chk_results(64'h0, 20'h0, 4'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("stray_ready_in", 32'(ready_in), 32'd1);
      chk("stray_valid_out", 32'(valid_out), 32'd0);
      chk_results(64'h0, 20'h0, 4'h0);

      // Next request after reset; NaN lane raises NV in its own lane only
      send(4'b1111, {16'h4110, 16'h3F80, 16'hFFC1, 16'h4080}, 4'hC, 3'd1);
      wait_done(n);
      chk("latency_after_rst", 32'(n), 32'd7);
      chk_results({16'h4040, 16'h3F80, 16'h7FC0, 16'h4000}, 20'h00200, 4'hC);
      handshake();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
